// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bypass select encodings and ID_CTRL bit layout.
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int RW     = 5;
  localparam int CTRL_W = 16;
  localparam int NSRC   = 2;

  // Select applied in EX next cycle.
  // EXMEM: take the result of the instruction now in EX.
  // MEMWB: take the result of the instruction now in MEM.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // ID_CTRL field positions. The bundle travels unmodified to EX/MEM/WB.
  localparam int CTRL_ALUOP_LSB   = 0;   // [3:0]   ALU operation
  localparam int CTRL_ALUOP_W     = 4;
  localparam int CTRL_ALUSRC      = 4;   // op2 = immediate
  localparam int CTRL_MEMWRITE    = 5;   // store
  localparam int CTRL_MEMSIZE_LSB = 6;   // [7:6]   byte/half/word
  localparam int CTRL_WBSEL_LSB   = 8;   // [9:8]   ALU/mem/PC+4
  localparam int CTRL_BRANCH      = 10;
  localparam int CTRL_JUMP        = 11;
  localparam int CTRL_RSVD_LSB    = 12;  // [15:12] reserved

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand select, bypass select and load-use stall detection.
module hazard_fwd_unit
  import pipeline_pkg::*;
(
  input  logic                      id_valid,
  input  logic [NSRC-1:0][RW-1:0]   id_rs,
  input  logic [NSRC-1:0]           id_use,
  input  logic [NSRC-1:0][XLEN-1:0] rf_data,
  input  logic                      ex_valid,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [RW-1:0]             ex_rd,
  input  logic [RW-1:0]             exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic [RW-1:0]             memwb_rd,
  input  logic                      memwb_regwrite,
  input  logic [XLEN-1:0]           memwb_data,
  input  logic                      flush,
  input  logic                      reset,
  output logic [NSRC-1:0][XLEN-1:0] op,
  output logic [NSRC-1:0][1:0]      fwd,
  output logic                      load_use,
  output logic                      stall
);

  logic [NSRC-1:0] src_hit;

  // Per-source operand value, bypass select, and match against the load in EX.
  always_comb begin
    op      = '0;
    fwd     = '0;
    src_hit = '0;
    for (int n = 0; n < NSRC; n++) begin
      // The write-back port and the reg_file read share a cycle, so the
      // value being written this cycle is captured here, not forwarded later.
      if (id_rs[n] == 5'd0)
        op[n] = '0;
      else if (memwb_regwrite && memwb_rd == id_rs[n])
        op[n] = memwb_data;
      else
        op[n] = rf_data[n];

      // A younger producer wins over an older one; x0 is never bypassed.
      if (!id_use[n] || id_rs[n] == 5'd0)
        fwd[n] = FWD_NONE;
      else if (ex_valid && ex_regwrite && ex_rd == id_rs[n])
        fwd[n] = FWD_EXMEM;
      else if (exmem_regwrite && exmem_rd == id_rs[n])
        fwd[n] = FWD_MEMWB;
      else
        fwd[n] = FWD_NONE;

      src_hit[n] = id_use[n] && (id_rs[n] == ex_rd);
    end
  end

  assign load_use = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) && |src_hit;
  // A flush or reset discards the decode slot anyway, so no need to freeze it.
  assign stall    = load_use && !flush && reset;

endmodule

// File: rtl/operand_stage.sv
// ID/EX pipeline register with operand capture, bypass select and load-use bubble.
module operand_stage
  import pipeline_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_VALID,
  input  logic [RW-1:0]     ID_RS1,
  input  logic [RW-1:0]     ID_RS2,
  input  logic [RW-1:0]     ID_RD,
  input  logic              ID_USE_RS1,
  input  logic              ID_USE_RS2,
  input  logic              ID_REGWRITE,
  input  logic              ID_MEMREAD,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [XLEN-1:0]   ID_IMM,
  input  logic [XLEN-1:0]   RF_DATA1,
  input  logic [XLEN-1:0]   RF_DATA2,
  input  logic [RW-1:0]     EXMEM_RD,
  input  logic              EXMEM_REGWRITE,
  input  logic [RW-1:0]     MEMWB_RD,
  input  logic              MEMWB_REGWRITE,
  input  logic [XLEN-1:0]   MEMWB_DATA,
  input  logic              FLUSH,
  output logic              STALL,
  output logic              EX_VALID,
  output logic              EX_REGWRITE,
  output logic              EX_MEMREAD,
  output logic [RW-1:0]     EX_RD,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic [XLEN-1:0]   EX_PC,
  output logic [XLEN-1:0]   EX_IMM,
  output logic [XLEN-1:0]   EX_OP1,
  output logic [XLEN-1:0]   EX_OP2,
  output logic [1:0]        EX_FWD1,
  output logic [1:0]        EX_FWD2
);

  logic [NSRC-1:0][XLEN-1:0] op;
  logic [NSRC-1:0][1:0]      fwd;
  logic                      load_use;

  hazard_fwd_unit u_hfu (
    .id_valid       (ID_VALID),
    .id_rs          ({ID_RS2, ID_RS1}),
    .id_use         ({ID_USE_RS2, ID_USE_RS1}),
    .rf_data        ({RF_DATA2, RF_DATA1}),
    .ex_valid       (EX_VALID),
    .ex_regwrite    (EX_REGWRITE),
    .ex_memread     (EX_MEMREAD),
    .ex_rd          (EX_RD),
    .exmem_rd       (EXMEM_RD),
    .exmem_regwrite (EXMEM_REGWRITE),
    .memwb_rd       (MEMWB_RD),
    .memwb_regwrite (MEMWB_REGWRITE),
    .memwb_data     (MEMWB_DATA),
    .flush          (FLUSH),
    .reset          (RESET),
    .op             (op),
    .fwd            (fwd),
    .load_use       (load_use),
    .stall          (STALL)
  );

  // ID/EX register: reset, flush and load-use all leave an all-zero bubble;
  // otherwise capture the decode slot, stripping side effects if it is empty.
  always_ff @(posedge CLK) begin
    if (!RESET || FLUSH || load_use) begin
      EX_VALID    <= 1'b0;
      EX_REGWRITE <= 1'b0;
      EX_MEMREAD  <= 1'b0;
      EX_RD       <= '0;
      EX_CTRL     <= '0;
      EX_PC       <= '0;
      EX_IMM      <= '0;
      EX_OP1      <= '0;
      EX_OP2      <= '0;
      EX_FWD1     <= FWD_NONE;
      EX_FWD2     <= FWD_NONE;
    end else begin
      EX_VALID    <= ID_VALID;
      EX_REGWRITE <= ID_VALID && ID_REGWRITE;
      EX_MEMREAD  <= ID_VALID && ID_MEMREAD;
      EX_RD       <= ID_RD;
      EX_CTRL     <= ID_VALID ? ID_CTRL : '0;
      EX_PC       <= ID_PC;
      EX_IMM      <= ID_IMM;
      EX_OP1      <= op[0];
      EX_OP2      <= op[1];
      EX_FWD1     <= ID_VALID ? fwd[0] : FWD_NONE;
      EX_FWD2     <= ID_VALID ? fwd[1] : FWD_NONE;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Randomized + directed bench for operand_stage against a rule-level reference model.
module tb_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET, ID_VALID, ID_USE_RS1, ID_USE_RS2, ID_REGWRITE, ID_MEMREAD;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD, EXMEM_RD, MEMWB_RD;
  logic        EXMEM_REGWRITE, MEMWB_REGWRITE, FLUSH;
  logic [15:0] ID_CTRL;
  logic [31:0] ID_PC, ID_IMM, RF_DATA1, RF_DATA2, MEMWB_DATA;
  logic        STALL, EX_VALID, EX_REGWRITE, EX_MEMREAD;
  logic [4:0]  EX_RD;
  logic [15:0] EX_CTRL;
  logic [31:0] EX_PC, EX_IMM, EX_OP1, EX_OP2;
  logic [1:0]  EX_FWD1, EX_FWD2;

  operand_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RD(ID_RD), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD), .ID_CTRL(ID_CTRL),
    .ID_PC(ID_PC), .ID_IMM(ID_IMM), .RF_DATA1(RF_DATA1), .RF_DATA2(RF_DATA2),
    .EXMEM_RD(EXMEM_RD), .EXMEM_REGWRITE(EXMEM_REGWRITE), .MEMWB_RD(MEMWB_RD),
    .MEMWB_REGWRITE(MEMWB_REGWRITE), .MEMWB_DATA(MEMWB_DATA), .FLUSH(FLUSH),
    .STALL(STALL), .EX_VALID(EX_VALID), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_RD(EX_RD), .EX_CTRL(EX_CTRL), .EX_PC(EX_PC),
    .EX_IMM(EX_IMM), .EX_OP1(EX_OP1), .EX_OP2(EX_OP2), .EX_FWD1(EX_FWD1),
    .EX_FWD2(EX_FWD2)
  );

  always #5 CLK = ~CLK;

  // What the EX stage should hold, as the pipeline rules describe it.
  typedef struct packed {
    bit        v, rw, mr;
    bit [4:0]  rd;
    bit [15:0] ctrl;
    bit [31:0] pc, imm, op1, op2;
    bit [1:0]  f1, f2;
  } ex_t;

  ex_t m;
  int  nvec = 0;
  int  nerr = 0;
  bit  last_stall = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register value seen by EX: x0 is zero, a same-cycle write-back is visible.
  function automatic bit [31:0] ref_op(bit [4:0] rs, bit [31:0] rf);
    if (rs == 0) return 0;
    if (MEMWB_REGWRITE && MEMWB_RD == rs) return MEMWB_DATA;
    return rf;
  endfunction

  // Where the value will come from next cycle: 1 = instruction now in EX, 2 = now in MEM.
  function automatic bit [1:0] ref_fwd(bit use_rs, bit [4:0] rs);
    if (!ID_VALID || !use_rs || rs == 0) return 0;
    if (m.v && m.rw && m.rd == rs) return 1;
    if (EXMEM_REGWRITE && EXMEM_RD == rs) return 2;
    return 0;
  endfunction

  function automatic bit ref_hazard();
    if (!(ID_VALID && m.v && m.mr && m.rd != 0)) return 0;
    return (ID_USE_RS1 && ID_RS1 == m.rd) || (ID_USE_RS2 && ID_RS2 == m.rd);
  endfunction

  // One clock: check STALL, predict the edge, check the registered outputs.
  task automatic cycle();
    bit  hz, st;
    ex_t nx;
    hz = ref_hazard();
    st = hz && !FLUSH && RESET;
    #1 chk("stall", STALL, st);
    nx = '0;
    if (RESET && !FLUSH && !hz) begin
      nx.v    = ID_VALID;
      nx.rw   = ID_VALID && ID_REGWRITE;
      nx.mr   = ID_VALID && ID_MEMREAD;
      nx.rd   = ID_RD;
      nx.ctrl = ID_VALID ? ID_CTRL : 16'h0;
      nx.pc   = ID_PC;
      nx.imm  = ID_IMM;
      nx.op1  = ref_op(ID_RS1, RF_DATA1);
      nx.op2  = ref_op(ID_RS2, RF_DATA2);
      nx.f1   = ref_fwd(ID_USE_RS1, ID_RS1);
      nx.f2   = ref_fwd(ID_USE_RS2, ID_RS2);
    end
    last_stall = st;
    @(posedge CLK);
    m = nx;
    #1;
    chk("ex_valid", EX_VALID, m.v);
    chk("ex_regwrite", EX_REGWRITE, m.rw);
    chk("ex_memread", EX_MEMREAD, m.mr);
    chk("ex_rd", EX_RD, m.rd);
    chk("ex_ctrl", EX_CTRL, m.ctrl);
    chk("ex_pc", EX_PC, m.pc);
    chk("ex_imm", EX_IMM, m.imm);
    chk("ex_op1", EX_OP1, m.op1);
    chk("ex_op2", EX_OP2, m.op2);
    chk("ex_fwd1", EX_FWD1, m.f1);
    chk("ex_fwd2", EX_FWD2, m.f2);
  endtask

  task automatic quiet();
    RESET = 1; FLUSH = 0;
    ID_VALID = 0; ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0; ID_USE_RS1 = 0; ID_USE_RS2 = 0;
    ID_REGWRITE = 0; ID_MEMREAD = 0; ID_CTRL = 0; ID_PC = 0; ID_IMM = 0;
    RF_DATA1 = 0; RF_DATA2 = 0;
    EXMEM_RD = 0; EXMEM_REGWRITE = 0; MEMWB_RD = 0; MEMWB_REGWRITE = 0; MEMWB_DATA = 0;
  endtask

  // Small register pool so that matches happen often.
  function automatic bit [4:0] rreg();
    if ($urandom_range(0, 4) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic rnd();
    if (!last_stall) begin  // a stalled decode slot is held by the front end
      ID_VALID = ($urandom_range(0, 5) != 0);
      ID_RS1 = rreg(); ID_RS2 = rreg(); ID_RD = rreg();
      ID_USE_RS1 = 1'($urandom); ID_USE_RS2 = 1'($urandom);
      ID_REGWRITE = 1'($urandom); ID_MEMREAD = ($urandom_range(0, 2) == 0);
      ID_CTRL = 16'($urandom); ID_PC = $urandom; ID_IMM = $urandom;
    end
    RF_DATA1 = $urandom; RF_DATA2 = $urandom;
    EXMEM_RD = rreg(); EXMEM_REGWRITE = 1'($urandom);
    MEMWB_RD = rreg(); MEMWB_REGWRITE = 1'($urandom); MEMWB_DATA = $urandom;
    FLUSH = ($urandom_range(0, 9) == 0);
    RESET = ($urandom_range(0, 39) != 0);
  endtask

  task automatic lw_x7();
    quiet();
    ID_VALID = 1; ID_REGWRITE = 1; ID_MEMREAD = 1; ID_RD = 7; ID_CTRL = 16'h0301;
    cycle();
  endtask

  initial begin
    m = '0;
    // Reset overrides a valid slot and a flush.
    quiet();
    RESET = 0; FLUSH = 1; ID_VALID = 1; ID_REGWRITE = 1; ID_PC = 32'h100; RF_DATA1 = 32'h55;
    cycle();
    cycle();
    chk("rst_valid", EX_VALID, 0);
    chk("rst_pc", EX_PC, 0);

    // Write-back to x5 while decode reads x5.
    quiet();
    ID_VALID = 1; ID_RS1 = 5; ID_USE_RS1 = 1; RF_DATA1 = 32'h1111_1111;
    MEMWB_REGWRITE = 1; MEMWB_RD = 5; MEMWB_DATA = 32'hDEADBEEF;
    cycle();
    chk("wb_op1", EX_OP1, 32'hDEADBEEF);
    chk("wb_fwd1", EX_FWD1, 0);

    // ALU producer x3 in EX, then in MEM.
    quiet();
    ID_VALID = 1; ID_REGWRITE = 1; ID_RD = 3;
    cycle();
    quiet();
    ID_VALID = 1; ID_RS2 = 3; ID_USE_RS2 = 1;
    cycle();
    chk("alu_fwd2_ex", EX_FWD2, 1);
    quiet();
    ID_VALID = 1; ID_RS2 = 3; ID_USE_RS2 = 1; EXMEM_RD = 3; EXMEM_REGWRITE = 1;
    cycle();
    chk("alu_fwd2_mem", EX_FWD2, 2);

    // Load-use: one stall, one bubble, then load with MEM/WB bypass.
    lw_x7();
    quiet();
    ID_VALID = 1; ID_RS1 = 7; ID_USE_RS1 = 1; ID_PC = 32'h40;
    #1 chk("lu_stall", STALL, 1);
    cycle();
    chk("lu_bubble", EX_VALID, 0);
    EXMEM_RD = 7; EXMEM_REGWRITE = 1;
    cycle();
    chk("lu_valid", EX_VALID, 1);
    chk("lu_fwd1", EX_FWD1, 2);
    chk("lu_pc", EX_PC, 32'h40);

    // Load-use under flush: no stall, nothing retained.
    lw_x7();
    quiet();
    ID_VALID = 1; ID_RS1 = 7; ID_USE_RS1 = 1; FLUSH = 1;
    #1 chk("fl_stall", STALL, 0);
    cycle();
    chk("fl_bubble", EX_VALID, 0);
    quiet();
    cycle();
    chk("fl_empty", EX_VALID, 0);

    // x0 targeted everywhere.
    quiet();
    ID_VALID = 1; ID_REGWRITE = 1; ID_RD = 0;
    cycle();
    quiet();
    ID_VALID = 1; ID_RS1 = 0; ID_USE_RS1 = 1; RF_DATA1 = 32'h123;
    EXMEM_RD = 0; EXMEM_REGWRITE = 1; MEMWB_RD = 0; MEMWB_REGWRITE = 1; MEMWB_DATA = 32'hFFFF;
    cycle();
    chk("x0_op1", EX_OP1, 0);
    chk("x0_fwd1", EX_FWD1, 0);

    // Reset in the middle of a load-use stall.
    lw_x7();
    quiet();
    ID_VALID = 1; ID_RS1 = 7; ID_USE_RS1 = 1; RESET = 0;
    #1 chk("rs_stall", STALL, 0);
    cycle();
    chk("rs_valid", EX_VALID, 0);
    chk("rs_rd", EX_RD, 0);
    RESET = 1;
    cycle();
    chk("rs_resume", EX_VALID, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rnd();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
